// File: rtl/chacha_block_sequencer.sv
// -----------------------------------------------------------------------------
// chacha_block_sequencer
//
// Multi-block job controller for a ChaCha20 core. One job (key, nonce, start
// counter, block count) is accepted in IDLE. For each block the sequencer
// fetches a 512-bit plaintext block, pulses core_start, waits for core_done,
// and hands the ciphertext downstream. Between blocks the block counter is
// incremented. A counter that would wrap past 32'hFFFF_FFFF aborts the job
// with a sticky err_wrap.
//
// Handshake rule for job_*, pt_* and ct_*: a transfer happens on every clock
// edge where valid and ready are both high. The producer holds valid and its
// payload stable until that edge. Ready never depends on valid in the same
// cycle.
//
// Optional feature (macro CHACHA_SEQ_WATCHDOG_EN): WAIT is bounded to
// TIMEOUT_CYC cycles. On expiry the job is abandoned, a sticky err_timeout is
// raised and done still pulses. Without the macro there is no err_timeout
// port and WAIT is unbounded.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   job_*               job request and payload (captured on handshake)
//   pt_*                plaintext block stream in
//   core_start/busy/done/ciphertext, core_key/nonce/counter/plaintext
//                       interface to the ChaCha20 core
//   ct_*                ciphertext block stream out (ct_last marks final block)
//   busy, done          job in progress / one-cycle job-complete pulse
//   err_wrap            counter-wrap abort, sticky until next job accept
//   err_timeout         watchdog abort (only with CHACHA_SEQ_WATCHDOG_EN)
//   dbg_state           current FSM state
//   dbg_blk_idx         number of blocks emitted in the current job
// -----------------------------------------------------------------------------
module chacha_block_sequencer #(
  parameter int BLK_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [255:0]      job_key,
  input  logic [95:0]       job_nonce,
  input  logic [31:0]       job_counter,
  input  logic [BLK_W-1:0]  job_blocks,
  input  logic              pt_valid,
  output logic              pt_ready,
  input  logic [511:0]      pt_data,
  output logic              core_start,
  input  logic              core_busy,
  input  logic              core_done,
  output logic [255:0]      core_key,
  output logic [95:0]       core_nonce,
  output logic [31:0]       core_counter,
  output logic [511:0]      core_plaintext,
  input  logic [511:0]      core_ciphertext,
  output logic              ct_valid,
  input  logic              ct_ready,
  output logic [511:0]      ct_data,
  output logic              ct_last,
  output logic              busy,
  output logic              done,
  output logic              err_wrap,
`ifdef CHACHA_SEQ_WATCHDOG_EN
  output logic              err_timeout,
`endif
  output logic [2:0]        dbg_state,
  output logic [BLK_W-1:0]  dbg_blk_idx
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_EMIT   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  // Keeps TIMEOUT_CYC referenced when the watchdog is compiled out.
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  state_t             state_q,     state_d;
  logic [255:0]       key_q,       key_d;
  logic [95:0]        nonce_q,     nonce_d;
  logic [31:0]        counter_q,   counter_d;
  logic [511:0]       pt_q,        pt_d;
  logic [511:0]       ct_data_q,   ct_data_d;
  logic               ct_valid_q,  ct_valid_d;
  logic               ct_last_q,   ct_last_d;
  logic [BLK_W-1:0]   remaining_q, remaining_d;
  logic [BLK_W-1:0]   blk_idx_q,   blk_idx_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic               err_wrap_q,  err_wrap_d;

`ifdef CHACHA_SEQ_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WD_W-1:0]    wd_q,        wd_d;
  logic               err_to_q,    err_to_d;
`endif

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    nonce_d     = nonce_q;
    counter_d   = counter_q;
    pt_d        = pt_q;
    ct_data_d   = ct_data_q;
    ct_valid_d  = ct_valid_q;
    ct_last_d   = ct_last_q;
    remaining_d = remaining_q;
    blk_idx_d   = blk_idx_q;
    busy_d      = busy_q;
    err_wrap_d  = err_wrap_q;
    // done is registered from FINISH, so it rises in the first IDLE cycle,
    // the same cycle a new job can already be accepted.
    done_d      = (state_q == S_FINISH);
`ifdef CHACHA_SEQ_WATCHDOG_EN
    wd_d        = wd_q;
    err_to_d    = err_to_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          key_d       = job_key;
          nonce_d     = job_nonce;
          counter_d   = job_counter;
          remaining_d = job_blocks;
          blk_idx_d   = '0;
          err_wrap_d  = 1'b0;
          busy_d      = 1'b1;
`ifdef CHACHA_SEQ_WATCHDOG_EN
          err_to_d    = 1'b0;
`endif
          state_d     = (job_blocks == '0) ? S_FINISH : S_FETCH;
        end
      end

      S_FETCH: begin
        if (pt_valid) begin
          pt_d    = pt_data;
          state_d = S_LAUNCH;
        end
      end

      // core_start is decoded from LAUNCH and gated by core_busy, so the
      // pulse is held off until the core is idle and lasts exactly one cycle.
      S_LAUNCH: begin
        if (!core_busy) begin
          state_d = S_WAIT;
`ifdef CHACHA_SEQ_WATCHDOG_EN
          wd_d    = '0;
`endif
        end
      end

      S_WAIT: begin
        if (core_done) begin
          ct_data_d  = core_ciphertext;
          ct_valid_d = 1'b1;
          ct_last_d  = (remaining_q == BLK_W'(1));
          state_d    = S_EMIT;
        end
`ifdef CHACHA_SEQ_WATCHDOG_EN
        else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          err_to_d = 1'b1;
          state_d  = S_FINISH;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end

      S_EMIT: begin
        if (ct_ready) begin
          ct_valid_d  = 1'b0;
          ct_last_d   = 1'b0;
          remaining_d = remaining_q - BLK_W'(1);
          blk_idx_d   = blk_idx_q + BLK_W'(1);
          if (remaining_q == BLK_W'(1)) begin
            state_d = S_FINISH;
          end else if (counter_q == 32'hFFFF_FFFF) begin
            // Next block would reuse counter 0 with the same key/nonce.
            err_wrap_d = 1'b1;
            state_d    = S_FINISH;
          end else begin
            counter_d = counter_q + 32'd1;
            state_d   = S_FETCH;
          end
        end
      end

      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      nonce_q     <= '0;
      counter_q   <= '0;
      pt_q        <= '0;
      ct_data_q   <= '0;
      ct_valid_q  <= 1'b0;
      ct_last_q   <= 1'b0;
      remaining_q <= '0;
      blk_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_wrap_q  <= 1'b0;
`ifdef CHACHA_SEQ_WATCHDOG_EN
      wd_q        <= '0;
      err_to_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      nonce_q     <= nonce_d;
      counter_q   <= counter_d;
      pt_q        <= pt_d;
      ct_data_q   <= ct_data_d;
      ct_valid_q  <= ct_valid_d;
      ct_last_q   <= ct_last_d;
      remaining_q <= remaining_d;
      blk_idx_q   <= blk_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_wrap_q  <= err_wrap_d;
`ifdef CHACHA_SEQ_WATCHDOG_EN
      wd_q        <= wd_d;
      err_to_q    <= err_to_d;
`endif
    end
  end

  assign job_ready      = (state_q == S_IDLE);
  assign pt_ready       = (state_q == S_FETCH);
  assign core_start     = (state_q == S_LAUNCH) && !core_busy;
  assign core_key       = key_q;
  assign core_nonce     = nonce_q;
  assign core_counter   = counter_q;
  assign core_plaintext = pt_q;
  assign ct_valid       = ct_valid_q;
  assign ct_data        = ct_data_q;
  assign ct_last        = ct_last_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_wrap       = err_wrap_q;
`ifdef CHACHA_SEQ_WATCHDOG_EN
  assign err_timeout    = err_to_q;
`endif
  assign dbg_state      = state_q;
  assign dbg_blk_idx    = blk_idx_q;

endmodule

// File: tb/tb_chacha_block_sequencer.sv
// -----------------------------------------------------------------------------
// tb_chacha_block_sequencer
//
// Directed, table-driven bench for chacha_block_sequencer. A behavioural core
// model answers each core_start after a configurable latency with
// ciphertext = plaintext ^ {16{counter}}. Expected ciphertext beats are
// computed from the plaintext the bench drove and the counter the bench
// expects for that block, and queued for the scoreboard.
// -----------------------------------------------------------------------------
module tb_chacha_block_sequencer;

  localparam int BLK_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             job_valid;
  logic             job_ready;
  logic [255:0]     job_key;
  logic [95:0]      job_nonce;
  logic [31:0]      job_counter;
  logic [BLK_W-1:0] job_blocks;
  logic             pt_valid;
  logic             pt_ready;
  logic [511:0]     pt_data;
  logic             core_start;
  logic             core_busy;
  logic             core_done;
  logic [255:0]     core_key;
  logic [95:0]      core_nonce;
  logic [31:0]      core_counter;
  logic [511:0]     core_plaintext;
  logic [511:0]     core_ciphertext;
  logic             ct_valid;
  logic             ct_ready;
  logic [511:0]     ct_data;
  logic             ct_last;
  logic             busy;
  logic             done;
  logic             err_wrap;
`ifdef CHACHA_SEQ_WATCHDOG_EN
  logic             err_timeout;
`endif
  logic [2:0]       dbg_state;
  logic [BLK_W-1:0] dbg_blk_idx;

  chacha_block_sequencer #(.BLK_W(BLK_W), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_key(job_key),
    .job_nonce(job_nonce), .job_counter(job_counter), .job_blocks(job_blocks),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
    .core_key(core_key), .core_nonce(core_nonce), .core_counter(core_counter),
    .core_plaintext(core_plaintext), .core_ciphertext(core_ciphertext),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .ct_last(ct_last), .busy(busy), .done(done), .err_wrap(err_wrap),
`ifdef CHACHA_SEQ_WATCHDOG_EN
    .err_timeout(err_timeout),
`endif
    .dbg_state(dbg_state), .dbg_blk_idx(dbg_blk_idx)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  typedef struct {
    logic [31:0] ctr;
    logic [15:0] blocks;
    int          lat;
    int          stall_beat;
    int          hang;
    int          exp_starts;
    int          exp_beats;
    int          exp_wrap;
    int          exp_lasts;
    int          exp_to;
    int          exp_done_lat;
  } vec_t;

  vec_t vecs[6];

  // scoreboard state
  logic [511:0] exp_q[$];
  logic         exp_last_q[$];
  logic [31:0]  start_ctrs[$];
  logic [31:0]  exp_ctr;
  int           exp_blocks;
  int           starts, beats, lasts, dones, pt_cnt, done_cyc;
  int           stall_beat = -1;
  int           stall_left = 0;
  int           core_lat = 4;
  logic         core_hang = 1'b0;
  logic         core_abort = 1'b0;
  logic         held = 1'b0;
  logic [511:0] held_data;
  logic         held_last;

  assign ct_ready = !(beats == stall_beat && stall_left > 0);

  // ---------------- core model ----------------
  initial begin
    logic [511:0] pt_snap;
    logic [31:0]  ctr_snap;
    int n;
    core_busy = 1'b0; core_done = 1'b0; core_ciphertext = '0;
    forever begin
      @(negedge clk);
      if (core_start && !rst) begin
        chk("start_while_busy", core_busy, 1'b0);
        starts++;
        start_ctrs.push_back(core_counter);
        pt_snap  = core_plaintext;
        ctr_snap = core_counter;
        @(posedge clk); #1;
        core_busy = 1'b1;
        n = 0;
        while (!core_abort && (core_hang || n < core_lat - 1)) begin
          @(posedge clk); #1;
          n++;
        end
        if (!core_abort) begin
          core_done = 1'b1;
          core_ciphertext = pt_snap ^ {16{ctr_snap}};
          @(posedge clk); #1;
          core_done = 1'b0;
          core_ciphertext = rand_blk();
        end
        core_busy = 1'b0;
      end
    end
  end

  // ---------------- plaintext driver ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && pt_valid && pt_ready) begin
        pt_cnt++;
        exp_q.push_back(pt_data ^ {16{exp_ctr}});
        exp_last_q.push_back(pt_cnt == exp_blocks);
        exp_ctr = exp_ctr + 32'd1;
        @(posedge clk); #1;
        pt_data = rand_blk();
      end
    end
  end

  // ---------------- ct / done monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        dones++;
        done_cyc = cyc;
      end
      if (!rst && ct_valid) begin
        if (held) begin
          chk("ct_data_stable", ct_data, held_data);
          chk("ct_last_stable", ct_last, held_last);
        end
        if (ct_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) chk("ct_unexpected_beat", 1'b1, 1'b0);
          else begin
            chk("ct_data", ct_data, exp_q.pop_front());
            chk("ct_last", ct_last, exp_last_q.pop_front());
          end
          beats++;
          if (ct_last) lasts++;
        end else begin
          held = 1'b1;
          held_data = ct_data;
          held_last = ct_last;
          if (beats == stall_beat && stall_left > 0) stall_left--;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_job(input vec_t v, output logic [255:0] key,
                           output logic [95:0] nonce, output int hs_cyc);
    exp_q.delete(); exp_last_q.delete(); start_ctrs.delete();
    starts = 0; beats = 0; lasts = 0; dones = 0; pt_cnt = 0;
    exp_ctr = v.ctr; exp_blocks = v.blocks;
    core_lat = v.lat; core_hang = v.hang[0];
    stall_beat = v.stall_beat; stall_left = 5;
    key = {rand_blk(), rand_blk()} >> 768;
    nonce = {$urandom, $urandom, $urandom};
    @(posedge clk); #1;
    job_key = key; job_nonce = nonce; job_counter = v.ctr; job_blocks = v.blocks;
    job_valid = 1'b1;
    pt_valid = 1'b1;
    pt_data = rand_blk();
    chk("job_ready_idle", job_ready, 1'b1);
    hs_cyc = cyc;
    @(posedge clk); #1;
    job_valid = 1'b0;
    // Scramble the request bus so late capture would be visible.
    job_key = ~key; job_nonce = ~nonce; job_counter = ~v.ctr; job_blocks = '1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [255:0] key;
    logic [95:0]  nonce;
    int hs_cyc, guard;
    logic [31:0] fin_ctr;
    start_job(v, key, nonce, hs_cyc);
    guard = 0;
    while (dones == 0 && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    chk("done_seen", dones > 0, 1'b1);
    if (v.exp_done_lat >= 0) chk("done_latency", done_cyc - hs_cyc, v.exp_done_lat);
    repeat (4) @(posedge clk);
    #3;
    fin_ctr = (v.exp_beats == 0) ? v.ctr : v.ctr + v.exp_beats - 1;
    chk("done_pulses",   dones,  1);
    chk("core_starts",   starts, v.exp_starts);
    chk("pt_accepted",   pt_cnt, v.exp_starts);
    chk("ct_beats",      beats,  v.exp_beats);
    chk("ct_last_count", lasts,  v.exp_lasts);
    chk("err_wrap",      err_wrap, v.exp_wrap[0]);
`ifdef CHACHA_SEQ_WATCHDOG_EN
    chk("err_timeout",   err_timeout, v.exp_to[0]);
`endif
    chk("busy_after",    busy, 1'b0);
    chk("job_ready_after", job_ready, 1'b1);
    chk("ct_valid_after", ct_valid, 1'b0);
    chk("core_counter_final", core_counter, fin_ctr);
    chk("core_key",      core_key, key);
    chk("core_nonce",    core_nonce, nonce);
    chk("blk_idx",       dbg_blk_idx, v.exp_beats);
    chk("exp_q_drained", exp_q.size(), 0);
    for (int i = 0; i < v.exp_starts; i++) begin
      if (start_ctrs.size() == 0) chk("start_ctr_missing", 1'b1, 1'b0);
      else chk("start_ctr", start_ctrs.pop_front(), v.ctr + i);
    end
    if (v.hang != 0) begin
      core_abort = 1'b1;
      repeat (2) @(posedge clk);
      #1 core_abort = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_job_ready"}, job_ready, 1'b1);
    chk({tag, "_pt_ready"}, pt_ready, 1'b0);
    chk({tag, "_core_start"}, core_start, 1'b0);
    chk({tag, "_core_key"}, core_key, '0);
    chk({tag, "_core_nonce"}, core_nonce, '0);
    chk({tag, "_core_counter"}, core_counter, '0);
    chk({tag, "_core_pt"}, core_plaintext, '0);
    chk({tag, "_ct_valid"}, ct_valid, 1'b0);
    chk({tag, "_ct_data"}, ct_data, '0);
    chk({tag, "_ct_last"}, ct_last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err_wrap"}, err_wrap, 1'b0);
    chk({tag, "_state"}, dbg_state, 3'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t rv;
    logic [255:0] key;
    logic [95:0]  nonce;
    int hs_cyc, guard, dones_before;

    rst = 1'b1; job_valid = 1'b0; job_key = '0; job_nonce = '0;
    job_counter = '0; job_blocks = '0; pt_valid = 1'b0; pt_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2 check_idle_outputs("reset");

    //          ctr           blk lat stl hng st bt wr ls to dl
    vecs[0] = '{32'h0000_0001, 16'd1, 20, -1, 0, 1, 1, 0, 1, 0, -1};
    vecs[1] = '{32'h0000_0010, 16'd4,  7,  1, 0, 4, 4, 0, 1, 0, -1};
    vecs[2] = '{32'h0000_0000, 16'd0,  5, -1, 0, 0, 0, 0, 0, 0,  2};
    vecs[3] = '{32'hFFFF_FFFE, 16'd5,  4, -1, 0, 2, 2, 1, 0, 0, -1};
    vecs[4] = '{32'hFFFF_FFFF, 16'd1,  3, -1, 0, 1, 1, 0, 1, 0, -1};
    vecs[5] = '{32'h1234_5678, 16'd3,  1, -1, 0, 3, 3, 0, 1, 0, -1};
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset while waiting on the core for block 2 of 3.
    rv = '{32'h0000_0100, 16'd3, 30, -1, 0, 3, 3, 0, 1, 0, -1};
    start_job(rv, key, nonce, hs_cyc);
    guard = 0;
    while (!(starts == 2 && dbg_state == 3'd3) && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("reached_wait_blk2", guard < 2000, 1'b1);
    rst = 1'b1;
    core_abort = 1'b1;
    dones_before = dones;
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check_idle_outputs("midreset");
    repeat (10) @(posedge clk);
    #1;
    chk("midreset_no_done", dones, dones_before);
    chk("midreset_no_restart", starts, 2);
    core_abort = 1'b0;
    rv = '{32'h0000_0007, 16'd1, 6, -1, 0, 1, 1, 0, 1, 0, -1};
    run_vec(rv);

`ifdef CHACHA_SEQ_WATCHDOG_EN
    rv = '{32'h0000_0040, 16'd2, 4, -1, 1, 1, 0, 0, 0, 1, -1};
    run_vec(rv);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
